// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_ctrl_pkg : shared FSM encoding and default geometry          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package data_mem_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 13;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_ctrl_if : request/response bus of the data memory controller |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface data_mem_ctrl_if
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [31:0]           req_addr;
    logic [31:0]           req_offset;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_offset, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_offset, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_bank : single-port RAM, byte-enable write, registered read   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_bank
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                en_i,
    input  wire logic                we_i,
    input  wire logic [DATA_W/8-1:0] be_i,
    input  wire logic [ADDR_W-1:0]   addr_i,
    input  wire logic [DATA_W-1:0]   wdata_i,
    output logic      [DATA_W-1:0]   rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Read port captures the pre-write word and only moves on reads, so it holds between them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_ctrl : clear-on-reset FSM, range check, display register     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    data_mem_ctrl_if.slave         bus,
    input  wire logic              disp_we,
    input  wire logic [DATA_W-1:0] disp_data,
    output logic      [DATA_W-1:0] disp_out,
    output logic                   busy
);
    localparam int               BE_W        = DATA_W / 8;
    localparam state_t           RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_WORD  = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                rsp_valid_q, rsp_err_q, rsp_rd_q;
    logic [DATA_W-1:0]   disp_q;

    logic [31:0]         w_eff;
    logic                w_in_range, w_ready, w_accept;
    logic                mem_en, mem_we;
    logic [BE_W-1:0]     mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata, mem_rdata;

    assign w_eff      = bus.req_addr + bus.req_offset;
    assign w_in_range = (w_eff >> ADDR_W) == 32'd0;
    assign w_ready    = (state_q == ST_RUN);
    assign w_accept   = bus.req_valid && w_ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_en    = 1'b0;
        mem_we    = bus.req_we;
        mem_be    = bus.req_be;
        mem_addr  = w_eff[ADDR_W-1:0];
        mem_wdata = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_WORD) state_d = ST_RUN;
            end
            default: begin
                mem_en = w_accept && w_in_range;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
            disp_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= w_accept;
            if (w_accept) begin
                rsp_err_q <= !w_in_range;
                rsp_rd_q  <= w_in_range && !bus.req_we;
            end
            if (disp_we) disp_q <= disp_data;
        end
    end

    data_mem_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // Writes and errors report zero data; the last read word is held until the next accept.
    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rd_q ? mem_rdata : '0;
    assign busy          = (state_q == ST_INIT);
    assign disp_out      = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_ctrl : directed scoreboard bench, ADDR_W=4 instance        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          disp_we;
    logic [DW-1:0] disp_data;
    logic [DW-1:0] disp_out;
    logic          busy;

    rsp_t          sb_q[$];
    logic [DW-1:0] model [DEPTH];
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if #(.DATA_W(DW)) bus ();

    data_mem_ctrl #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .disp_we   (disp_we),
        .disp_data (disp_data),
        .disp_out  (disp_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One request per cycle; callers chain calls to get back-to-back traffic.
    task automatic req(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] off, input logic [DW-1:0] wdata);
        logic [31:0] eff;
        rsp_t        e;
        rsp_t        got;
        eff = addr + off;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_be     = be;
        bus.req_addr   = addr;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        if (eff >= DEPTH) begin
            e = '{err: 1'b1, rdata: '0};
        end else if (we) begin
            e = '{err: 1'b0, rdata: '0};
            for (int b = 0; b < 4; b++)
                if (be[b]) model[eff[AW-1:0]][b*8 +: 8] = wdata[b*8 +: 8];
        end else begin
            e = '{err: 1'b0, rdata: model[eff[AW-1:0]]};
        end
        sb_q.push_back(e);
        check({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1;
        got = '{err: bus.rsp_err, rdata: bus.rsp_rdata};
        e   = sb_q.pop_front();
        check({tag, "_rsp"}, {31'd0, bus.rsp_valid, got}, {31'd0, 1'b1, e});
    endtask

    task automatic idle(input string tag);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check(tag, {63'd0, bus.rsp_valid}, 64'd0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'(DEPTH));
        check({tag, "_ready"}, {63'd0, bus.req_ready}, 64'd1);
        model_clear();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_be     = '0;
        bus.req_addr   = '0;
        bus.req_offset = '0;
        bus.req_wdata  = '0;
        disp_we        = 1'b0;
        disp_data      = '0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",  {63'd0, busy}, 64'd1);
        check("rst_ready", {63'd0, bus.req_ready}, 64'd0);
        check("rst_rsp",   {30'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
        check("rst_disp",  64'(disp_out), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("init_len");

        for (int i = 0; i < DEPTH; i++) req("rd_zero", 1'b0, 4'h0, 32'(i), 32'd0, '0);

        req("wr_dead", 1'b1, 4'hF, 32'd3, 32'd2, 32'hDEADBEEF);
        req("rd_dead", 1'b0, 4'h0, 32'd5, 32'd0, '0);
        check("rd_dead_const", 64'(bus.rsp_rdata), 64'hDEADBEEF);

        req("wr_full", 1'b1, 4'hF, 32'd7, 32'd0, 32'h11223344);
        req("wr_be2",  1'b1, 4'h2, 32'd7, 32'd0, 32'h0000AA00);
        req("rd_be2",  1'b0, 4'h0, 32'd7, 32'd0, '0);
        check("be_merge_const", 64'(bus.rsp_rdata), 64'h1122AA44);
        req("wr_be0",  1'b1, 4'h0, 32'd6, 32'd1, 32'hFFFFFFFF);
        req("rd_be0",  1'b0, 4'h0, 32'd7, 32'd0, '0);

        req("rd_wrap",  1'b0, 4'h0, 32'hFFFFFFFF, 32'h11, '0);
        req("wr_wrap",  1'b1, 4'hF, 32'hFFFFFFFF, 32'h11, 32'hCAFEBABE);
        req("rd_w0",    1'b0, 4'h0, 32'd0, 32'd0, '0);
        req("rd_depth", 1'b0, 4'h0, 32'd0, 32'd16, '0);
        req("rd_last",  1'b0, 4'h0, 32'd15, 32'd0, '0);

        req("rd_hold", 1'b0, 4'h0, 32'd5, 32'd0, '0);
        idle("idle_valid");
        check("hold_rdata", {31'd0, bus.rsp_err, bus.rsp_rdata}, 64'hDEADBEEF);

        disp_we   = 1'b1;
        disp_data = 32'h0000002A;
        req("wr_disp", 1'b1, 4'hF, 32'd9, 32'd0, 32'h12345678);
        disp_we   = 1'b0;
        disp_data = 32'h00000055;
        check("disp_load", 64'(disp_out), 64'h2A);
        req("rd_disp", 1'b0, 4'h0, 32'd9, 32'd0, '0);
        check("disp_held", 64'(disp_out), 64'h2A);

        // Reset right after accepting a read: its response must never appear.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd5;
        bus.req_offset = 32'd0;
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("run_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("run_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("run_rst_disp",  64'(disp_out), 64'd0);
        check("run_rst_busy",  {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("init_len_run_rst");

        // Abort clearing at counter 7 and confirm a full-length restart.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("init_rst_busy",  {63'd0, busy}, 64'd1);
        check("init_rst_ready", {63'd0, bus.req_ready}, 64'd0);
        check("init_rst_rsp",   {30'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init("init_len_restart");
        req("rd_after_clr5", 1'b0, 4'h0, 32'd5, 32'd0, '0);
        req("rd_after_clr9", 1'b0, 4'h0, 32'd9, 32'd0, '0);
        idle("idle_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 13, word-index width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero every word after reset, 0 = skip clearing.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_be  input  DATA_W/8  byte enables for writes.
REQ-010 SHALL have port req_addr  input  32  base word address.
REQ-011 SHALL have port req_offset  input  32  word offset added to base.
REQ-012 SHALL have port req_wdata  input  DATA_W  write data.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-014 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-015 SHALL have port rsp_err  output  1  out-of-range access.
REQ-016 SHALL have port disp_we  input  1  load display register.
REQ-017 SHALL have port disp_data  input  DATA_W  display load value.
REQ-018 SHALL have port disp_out  output  DATA_W  display register.
REQ-019 SHALL have port busy  output  1  clear sequence running.

Function
REQ-020 Request SHALL be accepted on a rising edge with req_valid && req_ready.
REQ-021 Effective address SHALL be (req_addr + req_offset) mod 2**32; word index = low ADDR_W bits.
REQ-022 Effective address >= DEPTH SHALL be out-of-range: no memory change, rsp_err=1, rsp_rdata=0.
REQ-023 In-range accepted write SHALL update only bytes whose req_be bit is 1; req_be=0 is a legal no-op write.
REQ-024 Every accepted request SHALL produce exactly one rsp_valid pulse on the following cycle (latency 1); no backpressure on responses.
REQ-025 For in-range read, rsp_rdata SHALL hold word content as of the acceptance edge's pre-write state; for writes rsp_rdata=0, rsp_err=0.
REQ-026 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-027 rsp_rdata/rsp_err SHALL hold their last value when rsp_valid=0.
REQ-028 States: INIT, RUN. INIT: busy=1, req_ready=0, clear counter writes 0 to word counter, counter 0..DEPTH-1, one word per cycle.
REQ-029 INIT->RUN after word DEPTH-1 is cleared (DEPTH cycles); in RUN, busy=0, req_ready=1 every cycle.
REQ-030 CLEAR_ON_RESET=0: first state after reset SHALL be RUN; memory contents undefined.
REQ-031 disp_we on an edge SHALL load disp_out <= disp_data, independent of state and request traffic.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=INIT (or RUN if CLEAR_ON_RESET=0), clear counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, disp_out=0, busy per state.
REQ-033 Reset during INIT or RUN SHALL abort work in flight; no response is issued for a request accepted the edge before reset; clearing restarts at word 0.

Structure
REQ-034 Shared package SHALL hold state encoding (INIT, RUN) and default DATA_W/ADDR_W constants.
REQ-035 Storage array SHALL be a sub-module data_mem_bank (single port, byte-enable write, registered read); controller holds FSM, range check, display register.

Verification
REQ-036 Reset, CLEAR_ON_RESET=1, ADDR_W=4 -> busy=1 for 16 cycles, then req_ready=1; read of every word returns 0.
REQ-037 Write addr=3 offset=2 data=0xDEADBEEF be=0xF, next read addr=5 offset=0 -> rsp_rdata=0xDEADBEEF one cycle after acceptance.
REQ-038 Write be=0x2 data=0x0000AA00 over 0x11223344 -> read returns 0x1122AA44.
REQ-039 ADDR_W=4, addr=0xFFFFFFFF offset=0x11 -> wraps to 0x10 -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-040 disp_we=1 disp_data=0x0000002A during concurrent write -> disp_out=0x2A next edge, memory write still correct.
REQ-041 rst_n pulled low mid-INIT at counter 7 -> outputs zero immediately; after release clearing restarts at 0, busy lasts full DEPTH cycles.
